// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares one single-port Data_Memory between the MEM stages of two cores.
//   A lone requester is granted in the same cycle. When both cores request
//   in one cycle, one core is granted and the other is stalled. The stalled
//   core keeps its inputs stable and is served in the following cycle.
//   Round-robin between the cores is the default. Two same-address cases
//   override it:
//     - one write and one read: the write goes first, so the read that
//       follows sees the new data;
//     - two writes: core 2 commits first, so the value left in memory is
//       core 1's.
//   Read data has zero latency. It is also captured into a per-core holding
//   register, and rdata_o shows that register in every other cycle.
//
// Configuration macro:
//   ARB_FIXED_PRIORITY_EN - core 1 always wins contention (overrides still
//                           apply) and the last-grant state is frozen.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cN_read_i / cN_write_i       core N MemRead / MemWrite (both = write)
//   cN_addr_i / cN_wdata_i       core N address / store data
//   cN_rdata_o                   core N load data
//   cN_stall_o                   core N must hold its MEM stage
//   mem_read_o / mem_write_o     strobes to Data_Memory
//   mem_addr_o / mem_wdata_o     address / store data to Data_Memory
//   mem_rdata_i                  combinational read data from Data_Memory
//   conflict_cnt_o               saturating count of contended cycles
module data_mem_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ADDR_MASK_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              c1_read_i,
  input  logic              c1_write_i,
  input  logic [DATA_W-1:0] c1_addr_i,
  input  logic [DATA_W-1:0] c1_wdata_i,
  output logic [DATA_W-1:0] c1_rdata_o,
  output logic              c1_stall_o,
  input  logic              c2_read_i,
  input  logic              c2_write_i,
  input  logic [DATA_W-1:0] c2_addr_i,
  input  logic [DATA_W-1:0] c2_wdata_i,
  output logic [DATA_W-1:0] c2_rdata_o,
  output logic              c2_stall_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       conflict_cnt_o
);

  // LAST1: core 1 won the last contention, so core 2 is favoured next.
  typedef enum logic {LAST1, LAST2} state_e;

  state_e            state_q;
  logic [DATA_W-1:0] c1_rdata_q, c2_rdata_q;
  logic [15:0]       cnt_q;

  logic req1, req2, wr1, wr2, same_addr, contend, win1;
  logic gnt1, gnt2, gnt1_rd, gnt2_rd;

  always_comb begin
    req1      = c1_read_i | c1_write_i;
    req2      = c2_read_i | c2_write_i;
    wr1       = c1_write_i;
    wr2       = c2_write_i;
    same_addr = (c1_addr_i[ADDR_MASK_W+1:2] == c2_addr_i[ADDR_MASK_W+1:2]);
    contend   = ~rst_i & req1 & req2;

    // The same-address rules take precedence over the rotation. Two writes
    // let core 2 go first, so core 1's value is the one that remains.
    if (same_addr && wr1 && wr2) begin
      win1 = 1'b0;
    end else if (same_addr && (wr1 != wr2)) begin
      win1 = wr1;
    end else begin
`ifdef ARB_FIXED_PRIORITY_EN
      win1 = 1'b1;
`else
      win1 = (state_q == LAST2);
`endif
    end

    // Reset blocks every grant, so requests made during reset are dropped
    // and nothing is committed in the reset cycle.
    gnt1    = ~rst_i & req1 & (~req2 | win1);
    gnt2    = ~rst_i & req2 & (~req1 | ~win1);
    gnt1_rd = gnt1 & ~wr1;
    gnt2_rd = gnt2 & ~wr2;

    c1_stall_o = ~rst_i & req1 & ~gnt1;
    c2_stall_o = ~rst_i & req2 & ~gnt2;

    mem_read_o  = gnt1_rd | gnt2_rd;
    mem_write_o = (gnt1 & wr1) | (gnt2 & wr2);
    mem_addr_o  = gnt2 ? c2_addr_i  : c1_addr_i;
    mem_wdata_o = gnt2 ? c2_wdata_i : c1_wdata_i;

    c1_rdata_o = gnt1_rd ? mem_rdata_i : c1_rdata_q;
    c2_rdata_o = gnt2_rd ? mem_rdata_i : c2_rdata_q;

    conflict_cnt_o = cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= LAST2;
      c1_rdata_q <= '0;
      c2_rdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      if (gnt1_rd) c1_rdata_q <= mem_rdata_i;
      if (gnt2_rd) c2_rdata_q <= mem_rdata_i;
      if (contend) begin
`ifndef ARB_FIXED_PRIORITY_EN
        state_q <= win1 ? LAST1 : LAST2;
`endif
        if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;

  logic        clk, rst;
  logic        c1_rd, c1_wr, c2_rd, c2_wr;
  logic [31:0] c1_a, c1_d, c2_a, c2_d;
  logic [31:0] c1_rdata, c2_rdata;
  logic        c1_stall, c2_stall;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_a, mem_wd, mem_rdata;
  logic [15:0] cnt;

  data_mem_arbiter #(.DATA_W(32), .ADDR_MASK_W(5)) dut (
    .clk_i(clk), .rst_i(rst),
    .c1_read_i(c1_rd), .c1_write_i(c1_wr), .c1_addr_i(c1_a), .c1_wdata_i(c1_d),
    .c1_rdata_o(c1_rdata), .c1_stall_o(c1_stall),
    .c2_read_i(c2_rd), .c2_write_i(c2_wr), .c2_addr_i(c2_a), .c2_wdata_i(c2_d),
    .c2_rdata_o(c2_rdata), .c2_stall_o(c2_stall),
    .mem_read_o(mem_rd), .mem_write_o(mem_wr), .mem_addr_o(mem_a),
    .mem_wdata_o(mem_wd), .mem_rdata_i(mem_rdata), .conflict_cnt_o(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_Memory model: word addressed, combinational read, write on edge.
  logic [31:0] mem [0:63];
  initial for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
  assign mem_rdata = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_wr) mem[mem_a[7:2]] <= mem_wd;

  typedef struct {
    string       name;
    logic        s1, s2, mrd, mwr;
    logic [31:0] maddr, mwd, r1, r2;
    logic [15:0] cnt;
    bit          cm;
    int unsigned mi;
    logic [31:0] mv;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  function automatic void ex(string n, logic s1, logic s2, logic mrd, logic mwr,
                             logic [31:0] ma, logic [31:0] md, logic [31:0] r1,
                             logic [31:0] r2, logic [15:0] c, bit cm = 1'b0,
                             int unsigned mi = 0, logic [31:0] mv = '0);
    exp_t e;
    e.name = n; e.s1 = s1; e.s2 = s2; e.mrd = mrd; e.mwr = mwr;
    e.maddr = ma; e.mwd = md; e.r1 = r1; e.r2 = r2; e.cnt = c;
    e.cm = cm; e.mi = mi; e.mv = mv;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string n, input string f, input logic [31:0] act,
                     input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", n, f, act, expv);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.name, "c1_stall", {31'b0, c1_stall}, {31'b0, e.s1});
        chk(e.name, "c2_stall", {31'b0, c2_stall}, {31'b0, e.s2});
        chk(e.name, "mem_read", {31'b0, mem_rd}, {31'b0, e.mrd});
        chk(e.name, "mem_write", {31'b0, mem_wr}, {31'b0, e.mwr});
        if (e.mrd || e.mwr) chk(e.name, "mem_addr", mem_a, e.maddr);
        if (e.mwr) chk(e.name, "mem_wdata", mem_wd, e.mwd);
        chk(e.name, "c1_rdata", c1_rdata, e.r1);
        chk(e.name, "c2_rdata", c2_rdata, e.r2);
        chk(e.name, "conflict_cnt", {16'b0, cnt}, {16'b0, e.cnt});
        if (e.cm) chk(e.name, "memory", mem[e.mi], e.mv);
      end
    end
  end

  task automatic drv(input logic r, input logic r1, input logic w1,
                     input logic [31:0] a1, input logic [31:0] d1,
                     input logic r2, input logic w2,
                     input logic [31:0] a2, input logic [31:0] d2);
    rst = r;
    c1_rd = r1; c1_wr = w1; c1_a = a1; c1_d = d1;
    c2_rd = r2; c2_wr = w2; c2_a = a2; c2_d = d2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] r1e, r2e;
  logic        w1;
  int unsigned waited;

  initial begin
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // Requests during reset are dropped: no stall, no access, no commit.
    drv(1, 0, 1, 0, 32'hFFFF, 0, 1, 0, 32'hEEEE);
    ex("reset", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0);
    tick();

    // Lone write: granted in the same cycle.
    drv(0, 0, 1, 8, 5, 0, 0, 0, 0);
    ex("solo_wr", 0, 0, 0, 1, 8, 5, 0, 0, 16'd0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex("solo_wr_commit", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 1, 2, 32'd5);
    tick();
    ex("reset_wr_dropped", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 1, 0, 32'h100);
    tick();

    // First contention after reset: core 1 wins, core 2 next cycle.
    drv(0, 1, 0, 0, 0, 1, 0, 4, 0);
    ex("cont_first", 0, 1, 1, 0, 0, 0, 32'h100, 0, 16'd0);
    tick();
    drv(0, 0, 0, 0, 0, 1, 0, 4, 0);
    ex("cont_second", 0, 0, 1, 0, 4, 0, 32'h100, 32'h101, 16'd1);
    tick();

    // Continuous reads at distinct addresses: the grant alternates.
    r1e = 32'h100; r2e = 32'h101;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_FIXED_PRIORITY_EN
      w1 = 1'b1;
`else
      w1 = (i % 2) == 1;
`endif
      drv(0, 1, 0, 16, 0, 1, 0, 20, 0);
      if (w1) begin
        r1e = 32'h104;
        ex("rr_c1", 0, 1, 1, 0, 16, 0, r1e, r2e, 16'(1 + i));
      end else begin
        r2e = 32'h105;
        ex("rr_c2", 1, 0, 1, 0, 20, 0, r1e, r2e, 16'(1 + i));
      end
      tick();
    end

    // Same address, core 1 reads, core 2 writes: the write goes first.
    drv(0, 1, 0, 12, 0, 0, 1, 12, 9);
    ex("raw_wr", 1, 0, 0, 1, 12, 9, r1e, r2e, 16'd5);
    tick();
    drv(0, 1, 0, 12, 0, 0, 0, 0, 0);
    r1e = 32'd9;
    ex("raw_rd", 0, 0, 1, 0, 12, 0, r1e, r2e, 16'd6);
    tick();

    // Two writes to the same address: core 2 first, core 1's value remains.
    drv(0, 0, 1, 24, 32'hAA, 0, 1, 24, 32'hBB);
    ex("ww_c2", 1, 0, 0, 1, 24, 32'hBB, r1e, r2e, 16'd6);
    tick();
    drv(0, 0, 1, 24, 32'hAA, 0, 0, 0, 0);
    ex("ww_c1", 0, 0, 0, 1, 24, 32'hAA, r1e, r2e, 16'd7);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex("ww_final", 0, 0, 0, 0, 0, 0, r1e, r2e, 16'd7, 1, 6, 32'hAA);
    tick();

    // Write-first also beats a state that favours the reader (core 1).
    drv(0, 1, 0, 28, 0, 0, 1, 28, 32'h77);
    ex("raw2_wr", 1, 0, 0, 1, 28, 32'h77, r1e, r2e, 16'd7);
    tick();
    drv(0, 1, 0, 28, 0, 0, 0, 0, 0);
    r1e = 32'h77;
    ex("raw2_rd", 0, 0, 1, 0, 28, 0, r1e, r2e, 16'd8);
    tick();

    // Core 2 stalled on a write, then reset: the pending write is dropped.
    drv(0, 1, 0, 0, 0, 0, 1, 4, 32'hDEAD);
    r1e = 32'h100;
    ex("pre_rst_cont", 0, 1, 1, 0, 0, 0, r1e, r2e, 16'd8);
    tick();
    drv(1, 0, 0, 0, 0, 0, 1, 4, 32'hDEAD);
    ex("rst_stalled", 0, 0, 0, 0, 0, 0, r1e, r2e, 16'd9);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    ex("post_rst", 0, 0, 0, 0, 0, 0, 0, 0, 16'd0, 1, 1, 32'h101);
    tick();

    // State is back to LAST2: core 1 wins the first contention again.
    drv(0, 1, 0, 8, 0, 1, 0, 12, 0);
    ex("post_rst_c1", 0, 1, 1, 0, 8, 0, 32'd5, 0, 16'd0);
    tick();
    drv(0, 0, 0, 0, 0, 1, 0, 12, 0);
    ex("post_rst_c2", 0, 0, 1, 0, 12, 0, 32'd5, 32'd9, 16'd1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
